// File: rtl/adder_result_buffer_pkg.sv
// Shared definitions for the adder result buffer: the default adder width and
// the layout of a packed {cout, overflow, sum} result entry.
package adder_result_buffer_pkg;

    localparam int unsigned ADDER_N  = 32;
    localparam int unsigned RESULT_W = ADDER_N + 2;

    // Flag positions are offsets above the sum field, so they stay valid for any N.
    localparam int unsigned OVF_OFS  = 0;
    localparam int unsigned COUT_OFS = 1;

    function automatic int unsigned result_w(input int unsigned n);
        return n + 2;
    endfunction

endpackage

// File: rtl/adder_result_buffer_fifo.sv
// result_fifo2: generic 2-entry valid/ready FIFO with 1-bit wrapping pointers.
// Storage is written only on push and is never cleared on pop.
module result_fifo2
    import adder_result_buffer_pkg::*;
#(
    parameter int unsigned W     = RESULT_W,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    if (DEPTH != 2) begin : g_depth_check
        $fatal(1, "result_fifo2 supports DEPTH == 2 only");
    end

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    // in_ready comes only from the registered count, never from out_ready.
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adder_result_buffer.sv
// Registered capture of adder {sum, cout, overflow} behind a 2-entry valid/ready
// buffer. Overflow statistics are built only with ADDER_RESULT_BUFFER_STATS_EN.
module adder_result_buffer
    import adder_result_buffer_pkg::*;
#(
    parameter int unsigned N     = ADDER_N,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_sum,
    input  logic             in_cout,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_cout,
    output logic             out_overflow,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] ovf_count,
    output logic             ovf_sticky
);

    localparam int unsigned W = result_w(N);

    if ((N < 4) || ((N % 4) != 0)) begin : g_width_check
        $fatal(1, "adder_result_buffer: N must be >= 4 and a multiple of 4");
    end

    logic [W-1:0] in_data;
    logic [W-1:0] out_data;

    assign in_data = {in_cout, in_overflow, in_sum};

    result_fifo2 #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign out_sum      = out_data[N-1:0];
    assign out_overflow = out_data[N + OVF_OFS];
    assign out_cout     = out_data[N + COUT_OFS];

`ifdef ADDER_RESULT_BUFFER_STATS_EN
    logic push;
    assign push = in_valid & in_ready;

    // stat_clr wins over a same-cycle overflow push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count  <= '0;
            ovf_sticky <= 1'b0;
        end else if (stat_clr) begin
            ovf_count  <= '0;
            ovf_sticky <= 1'b0;
        end else if (push && in_overflow) begin
            if (ovf_count != '1) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
            ovf_sticky <= 1'b1;
        end
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign ovf_count       = '0;
    assign ovf_sticky      = 1'b0;
`endif

endmodule

// File: tb/tb_adder_result_buffer.sv
// Self-checking bench for adder_result_buffer: directed scenarios followed by
// randomized adder traffic, all compared against a queue-based reference model.
module tb_adder_result_buffer;

    localparam int unsigned N       = 32;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_sum = '0;
    logic             in_cout = 1'b0;
    logic             in_overflow = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_sum;
    logic             out_cout;
    logic             out_overflow;
    logic             stat_clr = 1'b0;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_sticky;

    adder_result_buffer #(
        .N     (N),
        .DEPTH (2),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sum       (in_sum),
        .in_cout      (in_cout),
        .in_overflow  (in_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_cout     (out_cout),
        .out_overflow (out_overflow),
        .stat_clr     (stat_clr),
        .ovf_count    (ovf_count),
        .ovf_sticky   (ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t        q[$];
    int unsigned m_cnt = 0;
    bit          m_sticky = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() != 0) begin
            check("out_sum", 64'(out_sum), 64'(q[0].sum));
            check("out_cout", 64'(out_cout), 64'(q[0].cout));
            check("out_overflow", 64'(out_overflow), 64'(q[0].ovf));
        end
`ifdef ADDER_RESULT_BUFFER_STATS_EN
        check("ovf_count", 64'(ovf_count), 64'(m_cnt));
        check("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
`else
        check("ovf_count_off", 64'(ovf_count), 64'd0);
        check("ovf_sticky_off", 64'(ovf_sticky), 64'd0);
`endif
    endtask

    // One cycle: check current state, drive inputs, advance the model past the next edge.
    task automatic cyc(input bit iv, input logic [N-1:0] s, input bit co, input bit ov,
                       input bit ordy, input bit clr);
        bit push;
        bit pop;
        @(negedge clk);
        check_all();
        in_valid    = iv;
        in_sum      = s;
        in_cout     = co;
        in_overflow = ov;
        out_ready   = ordy;
        stat_clr    = clr;
        push = iv && (q.size() < 2);
        pop  = (q.size() != 0) && ordy;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(res_t'{sum: s, cout: co, ovf: ov});
        if (clr) begin
            m_cnt    = 0;
            m_sticky = 1'b0;
        end else if (push && ov) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            m_sticky = 1'b1;
        end
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, '0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    // Assert reset a few ns after a rising edge, i.e. mid-cycle.
    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        m_cnt    = 0;
        m_sticky = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_ovf_count", 64'(ovf_count), 64'd0);
        check("rst_ovf_sticky", 64'(ovf_sticky), 64'd0);
        in_valid = 1'b1;
        in_sum   = 32'hDEAD_BEEF;
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_valid", 64'(out_valid), 64'd0);
        end
        in_valid  = 1'b0;
        stat_clr  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
    endtask

    function automatic logic [63:0] exp_stat(input int unsigned v);
`ifdef ADDER_RESULT_BUFFER_STATS_EN
        return 64'(v);
`else
        return 64'(v & 0);
`endif
    endfunction

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N:0]   full;
        logic [N-1:0] s;

        async_reset();

        // Single-result latency and drain.
        cyc(1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_sum", 64'(out_sum), 64'h5);
        idle(1'b1);
        check("t1_empty", 64'(out_valid), 64'd0);

        // Fill, hold the third word under back-pressure, then drain in order.
        cyc(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_full", 64'(in_ready), 64'd0);
        cyc(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t2_head11", 64'(out_sum), 64'h11);
        cyc(1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t2_head22", 64'(out_sum), 64'h22);
        idle(1'b1);
        check("t2_head33", 64'(out_sum), 64'h33);
        idle(1'b1);

        // Simultaneous push and pop at count 1.
        cyc(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hBB, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_head_aa", 64'(out_sum), 64'hAA);
        idle(1'b0);
        check("t3_head_bb", 64'(out_sum), 64'hBB);
        check("t3_count1", 64'(in_ready), 64'd1);
        idle(1'b1);

        // Overflow statistics and clear priority.
        repeat (3) cyc(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("t4_count3", 64'(ovf_count), exp_stat(3));
        check("t4_sticky", 64'(ovf_sticky), exp_stat(1));
        cyc(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        check("t4_clr_count", 64'(ovf_count), 64'd0);
        check("t4_clr_sticky", 64'(ovf_sticky), 64'd0);

        // Saturation.
        repeat (5) cyc(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("t5_sat", 64'(ovf_count), exp_stat(CNT_MAX));

        // Asynchronous reset while full.
        cyc(1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h5678, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        check("t6_full", 64'(in_ready), 64'd0);
        async_reset();
        cyc(1'b1, 32'h0000_0042, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        check("t6_first_after_rst", 64'(out_sum), 64'h42);

        // Randomized adder traffic.
        for (int i = 0; i < 3000; i++) begin
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? (32'h7FFF_FFFF - a + 32'($urandom_range(0, 2))) : $urandom;
            full = {1'b0, a} + {1'b0, b};
            s    = full[N-1:0];
            cyc(($urandom_range(0, 3) != 0), s, full[N],
                (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]),
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
            if (i == 1500) async_reset();
        end
        @(negedge clk);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
